// File: rtl/branch_ctrl.sv
// Execute-stage branch resolution: decodes comparator results, issues a registered
// fetch redirect for taken control transfers and sequences the front-end flush.
module branch_ctrl #(
  parameter int unsigned W            = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ex_valid,
  input  logic         ex_is_branch,
  input  logic         ex_is_jal,
  input  logic         ex_is_jalr,
  input  logic [2:0]   ex_funct3,
  input  logic [W-1:0] ex_target,
  input  logic         equal,
  input  logic         lessthan,
  output logic         branch_unsigned,
  output logic         redirect_valid,
  output logic [W-1:0] redirect_pc,
  input  logic         redirect_ready,
  output logic         flush_if_id,
  output logic         flush_id_ex,
  output logic         stall_ex,
  output logic         illegal_branch,
  output logic         misaligned,
  output logic [W-1:0] taken_count
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   pc_q, pc_d;
  logic [W-1:0]   count_q, count_d;
  logic           rv_q, rv_d;
  logic           flush_q, flush_d;
  logic           stall_q, stall_d;
  logic           ill_q, ill_d;
  logic           mis_q, mis_d;

  logic           br_taken;
  logic           bad_funct3;
  logic           taken;
  logic           resolve;
  logic           go;
  logic [W-1:0]   target;

  assign branch_unsigned = ex_funct3[1];

  // Condition decode and target formation
  always_comb begin
    br_taken   = 1'b0;
    bad_funct3 = 1'b0;
    case (ex_funct3)
      3'b000:         br_taken = equal;
      3'b001:         br_taken = !equal;
      3'b100, 3'b110: br_taken = lessthan;
      3'b101, 3'b111: br_taken = !lessthan;
      default:        bad_funct3 = 1'b1;
    endcase
    target = ex_target;
    if (ex_is_jalr) target[0] = 1'b0;
    taken   = (ex_is_branch && br_taken) || ex_is_jal || ex_is_jalr;
    resolve = ex_valid && (state_q == IDLE);
    go      = resolve && taken && !target[1];
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    count_d = count_q;
    ill_d   = resolve && ex_is_branch && bad_funct3;
    mis_d   = resolve && taken && target[1];
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = REDIRECT;
          pc_d    = target;
          count_d = count_q + W'(1);
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_d = DRAIN;
          cnt_d   = CW'(FLUSH_CYCLES);
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rv_d    = (state_d == REDIRECT);
    stall_d = (state_d == REDIRECT);
    flush_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      count_q <= '0;
      rv_q    <= 1'b0;
      flush_q <= 1'b0;
      stall_q <= 1'b0;
      ill_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      rv_q    <= rv_d;
      flush_q <= flush_d;
      stall_q <= stall_d;
      ill_q   <= ill_d;
      mis_q   <= mis_d;
    end
  end

  assign redirect_valid = rv_q;
  assign redirect_pc    = pc_q;
  assign flush_if_id    = flush_q;
  assign flush_id_ex    = flush_q;
  assign stall_ex       = stall_q;
  assign illegal_branch = ill_q;
  assign misaligned     = mis_q;
  assign taken_count    = count_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl; a narrow second instance covers
// taken_count wrap and a one-cycle flush.
module tb_branch_ctrl;

  logic        clk;
  logic        rst;
  logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_target;
  logic        equal, lessthan;
  logic        branch_unsigned, redirect_valid, redirect_ready;
  logic [31:0] redirect_pc, taken_count;
  logic        flush_if_id, flush_id_ex, stall_ex, illegal_branch, misaligned;

  logic        s_valid, s_branch, s_jal, s_jalr;
  logic [2:0]  s_funct3;
  logic [3:0]  s_target, s_pc, s_count;
  logic        s_equal, s_lessthan, s_unsigned, s_rv, s_ready;
  logic        s_fl1, s_fl2, s_stall, s_ill, s_mis;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  branch_ctrl #(.W(32), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3),
    .ex_target(ex_target), .equal(equal), .lessthan(lessthan),
    .branch_unsigned(branch_unsigned), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .stall_ex(stall_ex),
    .illegal_branch(illegal_branch), .misaligned(misaligned), .taken_count(taken_count)
  );

  branch_ctrl #(.W(4), .FLUSH_CYCLES(1)) dut_s (
    .clk(clk), .rst(rst), .ex_valid(s_valid), .ex_is_branch(s_branch),
    .ex_is_jal(s_jal), .ex_is_jalr(s_jalr), .ex_funct3(s_funct3),
    .ex_target(s_target), .equal(s_equal), .lessthan(s_lessthan),
    .branch_unsigned(s_unsigned), .redirect_valid(s_rv),
    .redirect_pc(s_pc), .redirect_ready(s_ready),
    .flush_if_id(s_fl1), .flush_id_ex(s_fl2), .stall_ex(s_stall),
    .illegal_branch(s_ill), .misaligned(s_mis), .taken_count(s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jal = 1'b0; ex_is_jalr = 1'b0;
    ex_funct3 = 3'b000; ex_target = '0; equal = 1'b0; lessthan = 1'b0;
  endtask

  task automatic s_clr();
    s_valid = 1'b0; s_branch = 1'b0; s_jal = 1'b0; s_jalr = 1'b0;
    s_funct3 = 3'b000; s_target = '0; s_equal = 1'b0; s_lessthan = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_rv"}, redirect_valid, 0);
    check({tag, "_flush_if"}, flush_if_id, 0);
    check({tag, "_flush_id"}, flush_id_ex, 0);
    check({tag, "_stall"}, stall_ex, 0);
  endtask

  // {funct3, equal, lessthan, taken, illegal}
  logic [6:0] vec [13] = '{
    7'b000_10_1_0, 7'b000_01_0_0, 7'b001_00_1_0, 7'b001_10_0_0,
    7'b100_01_1_0, 7'b100_10_0_0, 7'b101_00_1_0, 7'b101_01_0_0,
    7'b110_01_1_0, 7'b111_00_1_0, 7'b111_01_0_0, 7'b010_11_0_1,
    7'b011_00_0_1
  };

  initial begin
    logic [6:0] v;
    clr(); s_clr();
    redirect_ready = 1'b1; s_ready = 1'b1;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_quiet("reset");
    check("reset_pc", redirect_pc, 0);
    check("reset_ill", illegal_branch, 0);
    check("reset_mis", misaligned, 0);
    check("reset_cnt", taken_count, 0);
    check("reset_s_cnt", s_count, 0);

    // Taken BEQ with immediate accept
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_funct3 = 3'b000; equal = 1'b1;
    ex_target = 32'h100;
    #1 check("beq_unsigned", branch_unsigned, 0);
    tick(); clr(); exp_cnt++;
    check("beq_rv", redirect_valid, 1);
    check("beq_pc", redirect_pc, 32'h100);
    check("beq_flush_if", flush_if_id, 1);
    check("beq_flush_id", flush_id_ex, 1);
    check("beq_stall", stall_ex, 1);
    check("beq_cnt", taken_count, 1);
    tick();
    check("beq_d1_rv", redirect_valid, 0);
    check("beq_d1_flush", flush_if_id, 1);
    check("beq_d1_stall", stall_ex, 0);
    tick();
    check("beq_d2_flush", flush_id_ex, 1);
    tick();
    check_quiet("beq_idle");

    // Backpressure: BLTU held in REDIRECT four cycles while junk arrives
    redirect_ready = 1'b0;
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_funct3 = 3'b110; lessthan = 1'b1;
    ex_target = 32'h300;
    #1 check("bltu_unsigned", branch_unsigned, 1);
    tick(); clr(); exp_cnt++;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp%0d_rv", i), redirect_valid, 1);
      check($sformatf("bp%0d_pc", i), redirect_pc, 32'h300);
      check($sformatf("bp%0d_stall", i), stall_ex, 1);
      check($sformatf("bp%0d_ill", i), illegal_branch, 0);
      clr();
      ex_valid = 1'b1;
      if (i % 2 == 0) begin ex_is_jal = 1'b1; ex_target = 32'h500; end
      else begin ex_is_branch = 1'b1; ex_funct3 = 3'b010; end
      redirect_ready = (i == 3);
      tick();
    end
    clr();
    check("bp_drain_rv", redirect_valid, 0);
    check("bp_drain_flush", flush_if_id, 1);
    check("bp_drain_ill", illegal_branch, 0);
    check("bp_drain_cnt", taken_count, 32'(exp_cnt));
    tick(); tick();
    check_quiet("bp_idle");
    check("bp_idle_cnt", taken_count, 32'(exp_cnt));

    // Not-taken BNE then illegal funct3
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_funct3 = 3'b001; equal = 1'b1;
    ex_target = 32'h700;
    tick();
    ex_funct3 = 3'b011; equal = 1'b0;
    check("bne_rv", redirect_valid, 0);
    check("bne_ill", illegal_branch, 0);
    tick(); clr();
    check("ill_pulse", illegal_branch, 1);
    check("ill_rv", redirect_valid, 0);
    tick();
    check("ill_clear", illegal_branch, 0);
    check("ill_cnt", taken_count, 32'(exp_cnt));

    // JALR alignment
    ex_valid = 1'b1; ex_is_jalr = 1'b1; ex_target = 32'h203;
    tick(); clr();
    check("jalr_mis", misaligned, 1);
    check_quiet("jalr_mis");
    tick();
    check("jalr_mis_clear", misaligned, 0);
    check("jalr_mis_cnt", taken_count, 32'(exp_cnt));
    ex_valid = 1'b1; ex_is_jalr = 1'b1; ex_target = 32'h201;
    tick(); clr(); exp_cnt++;
    check("jalr_rv", redirect_valid, 1);
    check("jalr_pc", redirect_pc, 32'h200);
    check("jalr_mis0", misaligned, 0);
    check("jalr_cnt", taken_count, 32'(exp_cnt));
    tick(); tick(); tick();
    check_quiet("jalr_idle");

    // Condition decode table
    for (int k = 0; k < 13; k++) begin
      v = vec[k];
      ex_valid = 1'b1; ex_is_branch = 1'b1; ex_funct3 = v[6:4];
      equal = v[3]; lessthan = v[2]; ex_target = 32'h1000 + 32'(k * 16);
      tick(); clr();
      if (v[1]) exp_cnt++;
      check($sformatf("dec%0d_rv", k), redirect_valid, 32'(v[1]));
      check($sformatf("dec%0d_ill", k), illegal_branch, 32'(v[0]));
      check($sformatf("dec%0d_cnt", k), taken_count, 32'(exp_cnt));
      if (v[1]) begin
        check($sformatf("dec%0d_pc", k), redirect_pc, 32'h1000 + 32'(k * 16));
        tick(); tick(); tick();
      end else begin
        tick();
      end
    end

    // Reset during the second DRAIN cycle
    ex_valid = 1'b1; ex_is_jal = 1'b1; ex_target = 32'h40;
    tick(); clr(); exp_cnt++;
    check("rstd_cnt_pre", taken_count, 32'(exp_cnt));
    tick(); tick();
    check("rstd_drain2", flush_if_id, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_quiet("rstd");
    check("rstd_pc", redirect_pc, 0);
    check("rstd_cnt", taken_count, 0);
    tick();
    ex_valid = 1'b1; ex_is_jal = 1'b1; ex_target = 32'h80;
    tick(); clr();
    check("rstd_jal_rv", redirect_valid, 1);
    check("rstd_jal_pc", redirect_pc, 32'h80);
    check("rstd_jal_cnt", taken_count, 1);
    tick(); tick(); tick();

    // Reset while REDIRECT is held drops the pending redirect
    redirect_ready = 1'b0;
    ex_valid = 1'b1; ex_is_jal = 1'b1; ex_target = 32'h90;
    tick(); clr();
    check("rstr_rv_pre", redirect_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; redirect_ready = 1'b1;
    check_quiet("rstr");
    check("rstr_pc", redirect_pc, 0);
    check("rstr_cnt", taken_count, 0);
    tick();
    check_quiet("rstr_after");

    // Counter wrap on the 4-bit instance, FLUSH_CYCLES=1
    for (int k = 0; k < 15; k++) begin
      s_valid = 1'b1; s_jal = 1'b1; s_target = 4'h0;
      tick(); s_clr();
      tick(); tick();
    end
    check("wrap_pre_cnt", s_count, 4'hF);
    s_valid = 1'b1; s_branch = 1'b1; s_funct3 = 3'b101; s_lessthan = 1'b0;
    s_target = 4'h4;
    tick(); s_clr();
    check("wrap_rv", s_rv, 1);
    check("wrap_pc", s_pc, 4'h4);
    check("wrap_cnt", s_count, 0);
    tick();
    check("wrap_drain_flush", s_fl1, 1);
    check("wrap_drain_rv", s_rv, 0);
    tick();
    check("wrap_idle_flush", s_fl2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch resolution controller for the execute stage of the RV32I core. It drives the branch comparator's signed/unsigned select and decodes the comparator's `equal`/`lessthan` results per `funct3`. The core uses static not-taken prediction, so the block issues a registered PC redirect to fetch for every taken branch, JAL and JALR, then sequences the front-end pipeline flush. It also keeps a count of taken control transfers.

## Interface
- `W`, 32, datapath/PC width.
- `FLUSH_CYCLES`, 2, cycles of flush held after the redirect handshake; legal range 1..15.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ex_valid`  in  1  execute stage holds a valid instruction.
- `ex_is_branch` / `ex_is_jal` / `ex_is_jalr`  in  1 each  instruction class; at most one set.
- `ex_funct3`  in  3  branch condition code.
- `ex_target`  in  W  target computed by the ALU.
- `equal`, `lessthan`  in  1 each  comparator results, valid in the same cycle as `ex_*`.
- `branch_unsigned`  out  1  comparator select, combinational: `ex_funct3[1]`.
- `redirect_valid`  out  1  fetch redirect request.
- `redirect_pc`  out  W  redirect address, stable while `redirect_valid`=1.
- `redirect_ready`  in  1  fetch accepts the redirect.
- `flush_if_id`, `flush_id_ex`  out  1 each  squash younger pipeline registers.
- `stall_ex`  out  1  hold the execute stage.
- `illegal_branch`  out  1  one-cycle pulse: branch with `funct3` 010 or 011.
- `misaligned`  out  1  one-cycle pulse: taken target has bit[1] set.
- `taken_count`  out  W  count of redirects issued.

## Operation
- **Taken decode** (for `ex_is_branch`):
  - 000 BEQ: `equal`
  - 001 BNE: `!equal`
  - 100 BLT / 110 BLTU: `lessthan`
  - 101 BGE / 111 BGEU: `!lessthan`
  - 010 / 011: not taken; raise `illegal_branch`.
- JAL and JALR are always taken.
- **Target formation:** for JALR, bit[0] of `ex_target` is forced to 0. For all classes, a target with bit[1]=1 raises `misaligned`; no redirect is issued and `taken_count` does not change.
- **FSM states:** IDLE, REDIRECT, DRAIN.
  - IDLE → REDIRECT: `ex_valid` and taken and aligned. `redirect_pc` is latched and `taken_count` increments (wraps from 2^W−1 to 0).
  - IDLE → IDLE: not-taken, illegal or misaligned resolution. `illegal_branch` or `misaligned` pulses in the next cycle.
  - REDIRECT: `redirect_valid`=1, `stall_ex`=1, both flushes=1. Stays in REDIRECT until `redirect_ready`=1. On handshake, loads the drain counter with `FLUSH_CYCLES` and moves to DRAIN.
  - DRAIN: both flushes=1, `stall_ex`=0, `redirect_valid`=0. The counter decrements each cycle; the state returns to IDLE when the counter reaches 1.
- In REDIRECT and DRAIN all `ex_*` inputs are ignored, because the instructions they carry are being flushed. No pulse outputs and no count changes occur in these states.
- **Reset values:** state IDLE, every output 0, `redirect_pc`=0, `taken_count`=0, drain counter 0.
- Reset asserted in REDIRECT or DRAIN aborts the sequence. The pending redirect is dropped and outputs are 0 in the cycle after the reset edge.

## Timing
- Resolution is captured at edge N, the cycle in which `ex_valid` is high in IDLE.
- `redirect_valid`, flushes and pulses rise at N+1. All outputs except `branch_unsigned` are registered.
- If `redirect_ready`=1 at N+1: DRAIN spans N+2 .. N+1+`FLUSH_CYCLES`, and the block is in IDLE at N+2+`FLUSH_CYCLES`.
- Minimum spacing between two redirects is therefore `FLUSH_CYCLES`+2 cycles.
- Each cycle of `redirect_ready`=0 extends REDIRECT by one cycle. `redirect_pc` must not change while REDIRECT is held.
- A not-taken branch costs 0 stall cycles. `ex_valid` may be high in back-to-back cycles while in IDLE.

## Test plan
- **Taken BEQ:** funct3=000, `equal`=1, `ex_target`=0x0000_0100, `redirect_ready`=1.
  → `redirect_valid`=1 and `redirect_pc`=0x100 at N+1; flushes high N+1..N+3; IDLE at N+4; `taken_count`=1.
- **Backpressure:** taken BLTU (funct3=110, `lessthan`=1), `redirect_ready` low for 3 cycles.
  → `branch_unsigned`=1 in the resolve cycle; REDIRECT held 4 cycles with `redirect_pc` constant and `stall_ex`=1; `ex_valid` pulses during this window are ignored.
- **Not taken and illegal:** BNE with `equal`=1, then funct3=011 in the next cycle.
  → no redirect; `illegal_branch` pulses exactly one cycle (N+2); `taken_count` unchanged.
- **JALR alignment:** JALR with target 0x0000_0203.
  → `redirect_pc`=0x202 is not issued because bit[1]=1; `misaligned` pulses, count unchanged.
  JALR with target 0x0000_0201.
  → `redirect_pc`=0x200.
- **Reset mid-operation:** `rst` asserted during the second DRAIN cycle.
  → next cycle IDLE, all outputs 0, `taken_count`=0; a new taken JAL one cycle later redirects normally.
- **Counter wrap:** force `taken_count`=0xFFFF_FFFF via prior history or a backdoor, then issue a taken BGE (`lessthan`=0).
  → `taken_count`=0.
